// File: rtl/serial_pattern_detector_16bits_if.sv
// Bit-stream and status bundle between a pattern source and the 16-bit detector.
// The master drives the stream, enable and pattern; the slave returns window and lock status.
interface serial_pattern_detector_16bits_if;
    logic        serial_in;
    logic        E;
    logic        load;
    logic [15:0] pattern_in;
    logic [15:0] shift_q;
    logic        filled;
    logic        match;
    logic        locked;
    logic [3:0]  err_cnt;

    modport master (
        output serial_in, E, load, pattern_in,
        input  shift_q, filled, match, locked, err_cnt
    );

    modport slave (
        input  serial_in, E, load, pattern_in,
        output shift_q, filled, match, locked, err_cnt
    );
endinterface

// File: rtl/serial_pattern_detector_16bits.sv
// MSB-first deserializer with 16-bit pattern compare, period lock FSM and miss counting.
// Latency: outputs registered, valid the cycle after the sampling edge; no backpressure, E gates sampling.
module serial_pattern_detector_16bits (
    input  logic                            CLK,
    input  logic                            CLR,
    serial_pattern_detector_16bits_if.slave bus
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [15:0] win_q, win_d;
    logic [15:0] pattern_q, pattern_d;
    logic [4:0]  fill_cnt_q, fill_cnt_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  miss_cnt_q, miss_cnt_d;
    logic [3:0]  err_cnt_q, err_cnt_d;
    logic        filled_q, filled_d;
    logic        match_q, match_d;

    logic [15:0] window;
    logic [4:0]  fill_next;
    logic        hit;
    logic        boundary;

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        pattern_d  = pattern_q;
        fill_cnt_d = fill_cnt_q;
        phase_d    = phase_q;
        miss_cnt_d = miss_cnt_q;
        err_cnt_d  = err_cnt_q;
        filled_d   = filled_q;
        match_d    = 1'b0;

        window    = {win_q[14:0], bus.serial_in};
        fill_next = (fill_cnt_q == 5'd16) ? 5'd16 : fill_cnt_q + 5'd1;
        hit       = (fill_next == 5'd16) && (window == pattern_q);
        boundary  = (phase_q == 4'd15);

        if (bus.load) begin
            pattern_d  = bus.pattern_in;
            fill_cnt_d = 5'd0;
            phase_d    = 4'd0;
            miss_cnt_d = 4'd0;
            filled_d   = 1'b0;
            state_d    = HUNT;
        end else if (bus.E) begin
            win_d      = window;
            fill_cnt_d = fill_next;
            filled_d   = (fill_next == 5'd16);
            match_d    = hit;

            // Only the hit exactly one period after the alignment hit counts.
            case (state_q)
                HUNT: begin
                    if (hit) begin
                        state_d = VERIFY;
                        phase_d = 4'd0;
                    end
                end
                VERIFY: begin
                    phase_d = phase_q + 4'd1;
                    if (boundary) begin
                        if (hit) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 4'd0;
                        end else begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCKED: begin
                    phase_d = phase_q + 4'd1;
                    if (boundary) begin
                        if (hit) begin
                            miss_cnt_d = 4'd0;
                        end else begin
                            if (err_cnt_q != 4'd15) begin
                                err_cnt_d = err_cnt_q + 4'd1;
                            end
                            if (miss_cnt_q == 4'd1) begin
                                state_d    = HUNT;
                                miss_cnt_d = 4'd0;
                            end else begin
                                miss_cnt_d = miss_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q    <= HUNT;
            win_q      <= 16'd0;
            pattern_q  <= 16'd0;
            fill_cnt_q <= 5'd0;
            phase_q    <= 4'd0;
            miss_cnt_q <= 4'd0;
            err_cnt_q  <= 4'd0;
            filled_q   <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            pattern_q  <= pattern_d;
            fill_cnt_q <= fill_cnt_d;
            phase_q    <= phase_d;
            miss_cnt_q <= miss_cnt_d;
            err_cnt_q  <= err_cnt_d;
            filled_q   <= filled_d;
            match_q    <= match_d;
        end
    end

    assign bus.shift_q = win_q;
    assign bus.filled  = filled_q;
    assign bus.match   = match_q;
    assign bus.locked  = (state_q == LOCKED);
    assign bus.err_cnt = err_cnt_q;
endmodule

// File: tb/tb_serial_pattern_detector_16bits.sv
// Directed bench for the serial pattern detector: fill, lock, miss/drop, enable gaps,
// periodic pattern and mid-operation load/clear.
module tb_serial_pattern_detector_16bits;
    logic clk;
    logic clr;
    int   checks;
    int   errors;
    int   nbit;
    logic [15:0] cur_pat;

    serial_pattern_detector_16bits_if bus ();

    serial_pattern_detector_16bits dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_clr();
        clr = 1'b1;
        bus.E = 1'b0;
        bus.load = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] p, input logic with_e);
        bus.pattern_in = p;
        bus.load = 1'b1;
        bus.E = with_e;
        bus.serial_in = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0;
        bus.E = 1'b0;
        cur_pat = p;
        nbit = 0;
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        bus.E = 1'b1;
        @(posedge clk); #1;
        bus.E = 1'b0;
    endtask

    task automatic send_pat_bit(input logic flip);
        int idx;
        idx = 15 - (nbit % 16);
        nbit++;
        send_bit(cur_pat[idx] ^ flip);
    endtask

    task automatic idle_cycle();
        bus.E = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b0;
        checks++; if (bus.shift_q !== 16'h0000) begin errors++; $display("FAIL reset_shift got %h exp 0000", bus.shift_q); end
        checks++; if (bus.filled !== 1'b0) begin errors++; $display("FAIL reset_filled got %b exp 0", bus.filled); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL reset_match got %b exp 0", bus.match); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", bus.locked); end
        checks++; if (bus.err_cnt !== 4'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", bus.err_cnt); end
    endtask

    task automatic test_fill();
        do_load(16'hA5C3, 1'b0);
        for (int n = 1; n <= 15; n++) begin
            send_pat_bit(1'b0);
            checks++; if (bus.filled !== 1'b0) begin errors++; $display("FAIL fill_filled bit %0d got %b exp 0", n, bus.filled); end
            checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL fill_match bit %0d got %b exp 0", n, bus.match); end
        end
        send_pat_bit(1'b0);
        checks++; if (bus.shift_q !== 16'hA5C3) begin errors++; $display("FAIL fill_shift16 got %h exp a5c3", bus.shift_q); end
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL fill_match16 got %b exp 1", bus.match); end
        checks++; if (bus.filled !== 1'b1) begin errors++; $display("FAIL fill_filled16 got %b exp 1", bus.filled); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL fill_locked16 got %b exp 0", bus.locked); end
    endtask

    task automatic test_lock();
        for (int n = 17; n <= 48; n++) begin
            send_pat_bit(1'b0);
            if (n == 17) begin
                checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL lock_match17 got %b exp 0", bus.match); end
            end
            if (n == 31) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_locked31 got %b exp 0", bus.locked); end
            end
            if (n == 32 || n == 48) begin
                checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL lock_match%0d got %b exp 1", n, bus.match); end
                checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL lock_locked%0d got %b exp 1", n, bus.locked); end
                checks++; if (bus.err_cnt !== 4'd0) begin errors++; $display("FAIL lock_err%0d got %0d exp 0", n, bus.err_cnt); end
            end
        end
    endtask

    task automatic test_miss_drop();
        for (int n = 49; n <= 144; n++) begin
            send_pat_bit(n == 56 || n == 88 || n == 104);
            case (n)
                64: begin
                    checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL miss_match64 got %b exp 0", bus.match); end
                    checks++; if (bus.err_cnt !== 4'd1) begin errors++; $display("FAIL miss_err64 got %0d exp 1", bus.err_cnt); end
                    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_locked64 got %b exp 1", bus.locked); end
                end
                80: begin
                    checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL miss_match80 got %b exp 1", bus.match); end
                    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_locked80 got %b exp 1", bus.locked); end
                end
                96: begin
                    checks++; if (bus.err_cnt !== 4'd2) begin errors++; $display("FAIL miss_err96 got %0d exp 2", bus.err_cnt); end
                    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_locked96 got %b exp 1", bus.locked); end
                end
                112: begin
                    checks++; if (bus.err_cnt !== 4'd3) begin errors++; $display("FAIL miss_err112 got %0d exp 3", bus.err_cnt); end
                    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_locked112 got %b exp 0", bus.locked); end
                end
                128: begin
                    checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL miss_match128 got %b exp 1", bus.match); end
                    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_locked128 got %b exp 0", bus.locked); end
                end
                143: begin
                    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL miss_locked143 got %b exp 0", bus.locked); end
                end
                144: begin
                    checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL miss_relock144 got %b exp 1", bus.locked); end
                    checks++; if (bus.err_cnt !== 4'd3) begin errors++; $display("FAIL miss_err144 got %0d exp 3", bus.err_cnt); end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_enable_gaps();
        do_clr();
        do_load(16'hA5C3, 1'b0);
        for (int n = 1; n <= 32; n++) begin
            send_pat_bit(1'b0);
            if (n == 16 || n == 32) begin
                checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL gap_match%0d got %b exp 1", n, bus.match); end
                checks++; if (bus.shift_q !== 16'hA5C3) begin errors++; $display("FAIL gap_shift%0d got %h exp a5c3", n, bus.shift_q); end
            end
            if (n == 31) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL gap_locked31 got %b exp 0", bus.locked); end
            end
            if (n == 32) begin
                checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL gap_locked32 got %b exp 1", bus.locked); end
            end
            for (int g = 0; g < 2; g++) begin
                idle_cycle();
                checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL gap_idle_match bit %0d got %b exp 0", n, bus.match); end
            end
        end
        checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL gap_locked_hold got %b exp 1", bus.locked); end
    endtask

    task automatic test_periodic();
        do_clr();
        do_load(16'h0000, 1'b0);
        for (int n = 1; n <= 64; n++) begin
            send_pat_bit(n == 41);
            if (n >= 16 && n <= 40) begin
                checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL per_match bit %0d got %b exp 1", n, bus.match); end
            end
            if (n >= 41 && n <= 56) begin
                checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL per_nomatch bit %0d got %b exp 0", n, bus.match); end
            end
            if (n == 57) begin
                checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL per_match57 got %b exp 1", bus.match); end
            end
            if (n == 31) begin
                checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL per_locked31 got %b exp 0", bus.locked); end
            end
            if (n == 32 || n == 48 || n == 64) begin
                checks++; if (bus.locked !== 1'b1) begin errors++; $display("FAIL per_locked%0d got %b exp 1", n, bus.locked); end
            end
            if (n == 48 || n == 64) begin
                checks++; if (bus.err_cnt !== 4'd1) begin errors++; $display("FAIL per_err%0d got %0d exp 1", n, bus.err_cnt); end
            end
        end
    endtask

    task automatic test_mid_control();
        do_load(16'hFFFF, 1'b1);
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_load_locked got %b exp 0", bus.locked); end
        checks++; if (bus.filled !== 1'b0) begin errors++; $display("FAIL mid_load_filled got %b exp 0", bus.filled); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL mid_load_match got %b exp 0", bus.match); end
        checks++; if (bus.err_cnt !== 4'd1) begin errors++; $display("FAIL mid_load_err got %0d exp 1", bus.err_cnt); end
        checks++; if (bus.shift_q !== 16'h0000) begin errors++; $display("FAIL mid_load_shift got %h exp 0000", bus.shift_q); end
        for (int n = 1; n <= 16; n++) send_pat_bit(1'b0);
        checks++; if (bus.match !== 1'b1) begin errors++; $display("FAIL mid_ffff_match got %b exp 1", bus.match); end
        checks++; if (bus.shift_q !== 16'hFFFF) begin errors++; $display("FAIL mid_ffff_shift got %h exp ffff", bus.shift_q); end
        do_clr();
        checks++; if (bus.shift_q !== 16'h0000) begin errors++; $display("FAIL mid_clr_shift got %h exp 0000", bus.shift_q); end
        checks++; if (bus.filled !== 1'b0) begin errors++; $display("FAIL mid_clr_filled got %b exp 0", bus.filled); end
        checks++; if (bus.match !== 1'b0) begin errors++; $display("FAIL mid_clr_match got %b exp 0", bus.match); end
        checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL mid_clr_locked got %b exp 0", bus.locked); end
        checks++; if (bus.err_cnt !== 4'd0) begin errors++; $display("FAIL mid_clr_err got %0d exp 0", bus.err_cnt); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nbit = 0;
        cur_pat = 16'h0000;
        clr = 1'b1;
        bus.serial_in = 1'b0;
        bus.E = 1'b0;
        bus.load = 1'b0;
        bus.pattern_in = 16'h0000;
        #1;
        test_reset();
        test_fill();
        test_lock();
        test_miss_drop();
        test_enable_gaps();
        test_periodic();
        test_mid_control();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
